// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the 8-bit datapath.
// One bit per cycle, result returned as a single register-file write pulse.
module muldiv_unit #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic [REGBITS-1:0] dst,
    output logic               busy,
    output logic               we3,
    output logic [REGBITS-1:0] wa3,
    output logic [WIDTH-1:0]   wd3
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [REGBITS-1:0] dst_q;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   opnd;
    // acc: product high half / partial remainder
    logic [WIDTH:0]     acc;
    // lo: multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0]   lo;

    logic               is_div;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     sub_d;
    logic               fits;
    logic [WIDTH-1:0]   result;

    assign is_div = op_q[1];

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        add_sum = {1'b0, acc[WIDTH-1:0]}
                + (lo[0] ? {1'b0, opnd} : '0);
        shl     = {acc[WIDTH-1:0], lo[WIDTH-1]};
        fits    = (shl >= {1'b0, opnd});
        sub_d   = shl - {1'b0, opnd};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (cnt == LAST) ? WB : RUN;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch and per-cycle datapath iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            dst_q <= '0;
            opnd  <= '0;
            acc   <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        dst_q <= dst;
                        cnt   <= '0;
                        acc   <= '0;
                        if (op[1]) begin
                            opnd <= srcb;
                            lo   <= srca;
                        end else begin
                            opnd <= srca;
                            lo   <= srcb;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc <= fits ? sub_d : shl;
                        lo  <= {lo[WIDTH-2:0], fits};
                    end else begin
                        acc <= {1'b0, add_sum[WIDTH:1]};
                        lo  <= {add_sum[0], lo[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and registered datapath only
    always_comb begin
        result = op_q[0] ? acc[WIDTH-1:0] : lo;
        busy   = (state != IDLE);
        we3    = (state == WB) && (dst_q != '0);
        wa3    = we3 ? dst_q : '0;
        wd3    = we3 ? result : '0;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: arithmetic reference model with per-cycle
// comparison plus directed vectors with hand-computed results.
module tb_muldiv_unit;

    localparam int W = 8;
    localparam int R = 3;

    logic         clk = 0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [R-1:0] dst;
    logic         busy;
    logic         we3;
    logic [R-1:0] wa3;
    logic [W-1:0] wd3;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit chk_en = 0;

    // reference model state: cycles remaining until idle
    int           m_cnt = 0;
    logic [W-1:0] m_res = '0;
    logic [R-1:0] m_dst = '0;

    muldiv_unit #(.WIDTH(W), .REGBITS(R)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .dst   (dst),
        .busy  (busy),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mres(input logic [1:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a * b;
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Model: accept in idle, busy for W+1 cycles, write in the last one
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt = W + 1;
                m_res = mres(op, srca, srcb);
                m_dst = dst;
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic m_we;
        if (chk_en) begin
            m_we = (m_cnt == 1) && (m_dst != 0);
            chk("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
            chk("we3", {31'b0, we3}, {31'b0, m_we});
            chk("wa3", {29'b0, wa3}, m_we ? {29'b0, m_dst} : 0);
            chk("wd3", {24'b0, wd3}, m_we ? {24'b0, m_res} : 0);
        end
        if (we3) pulses++;
    end

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [R-1:0] d,
                         input logic [W-1:0] exp, input bit inject,
                         input string nm);
        int lat = -1;
        int np = 0;
        int nb = 0;
        logic b10 = 1'b1;
        logic [W-1:0] got = '0;
        logic [R-1:0] gwa = '0;
        start = 1; op = o; srca = a; srcb = b; dst = d;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 0; op = ~o; srca = ~a; srcb = b + 1;
            end
            if (inject && i == 4) begin
                start = 1; op = 2'd2; srca = 9; srcb = 3;
            end
            if (inject && i == 5) start = 0;
            if (busy) nb++;
            if (we3) begin
                np++; lat = i; got = wd3; gwa = wa3;
            end
            if (i == 10) b10 = busy;
        end
        if (d != 0) begin
            chk({nm, "_lat"}, lat, 9);
            chk({nm, "_wd3"}, {24'b0, got}, {24'b0, exp});
            chk({nm, "_wa3"}, {29'b0, gwa}, {29'b0, d});
            chk({nm, "_pulses"}, np, 1);
        end else begin
            chk({nm, "_pulses"}, np, 0);
        end
        chk({nm, "_busycyc"}, nb, W + 1);
        chk({nm, "_busy_after"}, {31'b0, b10}, 0);
    endtask

    initial begin
        int np;
        int p0;
        int q[$];
        logic pb;
        reset = 1; start = 0; op = 0; srca = 0; srcb = 0; dst = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_we3", {31'b0, we3}, 0);
        chk("rst_wa3", {29'b0, wa3}, 0);
        chk("rst_wd3", {24'b0, wd3}, 0);
        reset = 0;
        chk_en = 1;

        chk("model_mullo", {24'b0, mres(2'd0, 8'd13, 8'd11)}, 32'h8F);
        chk("model_mulhi", {24'b0, mres(2'd1, 8'hFF, 8'hFF)}, 32'hFE);
        chk("model_divu", {24'b0, mres(2'd2, 8'd200, 8'd7)}, 32'h1C);
        chk("model_remu", {24'b0, mres(2'd3, 8'd200, 8'd7)}, 32'h04);
        chk("model_div0", {24'b0, mres(2'd2, 8'h5A, 8'd0)}, 32'hFF);
        chk("model_rem0", {24'b0, mres(2'd3, 8'h5A, 8'd0)}, 32'h5A);

        do_op(2'd0, 8'd13, 8'd11, 3'd3, 8'h8F, 0, "mullo");
        do_op(2'd1, 8'hFF, 8'hFF, 3'd3, 8'hFE, 0, "mulhi");
        do_op(2'd2, 8'd200, 8'd7, 3'd5, 8'h1C, 0, "divu");
        do_op(2'd3, 8'd200, 8'd7, 3'd5, 8'h04, 0, "remu");
        do_op(2'd2, 8'h5A, 8'd0, 3'd4, 8'hFF, 0, "div0");
        do_op(2'd3, 8'h5A, 8'd0, 3'd4, 8'h5A, 0, "rem0");
        do_op(2'd0, 8'd2, 8'd3, 3'd2, 8'h06, 1, "busy_start");

        // abort in the middle of RUN
        np = 0;
        start = 1; op = 0; srca = 7; srcb = 9; dst = 6;
        @(posedge clk);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start = 0;
            if (i == 4) reset = 1;
            if (i == 5) begin
                reset = 0;
                chk("abort_busy", {31'b0, busy}, 0);
            end
            if (we3) np++;
        end
        chk("abort_pulses", np, 0);
        do_op(2'd0, 8'd5, 8'd5, 3'd1, 8'h19, 0, "after_abort");
        do_op(2'd0, 8'd4, 8'd4, 3'd0, 8'h00, 0, "dst0");

        // start held high: accepts only from idle
        p0 = pulses;
        pb = busy;
        start = 1; op = 0; srca = 4; srcb = 4; dst = 0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !pb) q.push_back(i);
            pb = busy;
        end
        start = 0;
        repeat (12) @(negedge clk);
        chk("b2b_accepts", q.size(), 4);
        for (int k = 1; k < q.size(); k++)
            chk("b2b_spacing", q[k] - q[k-1], W + 2);
        chk("b2b_pulses", pulses - p0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
